pwm_dead_time_gen: RTL and testbench

Downstream consumer of the sine duty-cycle LUT stage. It turns the 32-bit duty word into a complementary pair of PWM gate signals with programmable dead time. It also generates the sample-request strobe that steps the LUT (drives its index input), so that one new duty value is fetched every PERIODS_PER_SAMPLE PWM periods. Sits between the LUT stage and the Basys3 output pins / H-bridge driver.

---
 rtl/pwm_pkg.sv | 27 ++
 rtl/pwm_dead_time_gen_if.sv | 23 ++
 rtl/dead_time_fsm.sv | 87 ++++++++
 rtl/pwm_dead_time_gen.sv | 86 ++++++++
 tb/tb_pwm_dead_time_gen.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared types and default timing constants for the sine PWM output stage.
package pwm_pkg;

   // Dead-time sequencer states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DEAD  = 2'd1,
      HI_ON = 2'd2,
      LO_ON = 2'd3
   } dt_state_t;

   localparam int CLK_HZ            = 100_000_000;
   localparam int SINE_HZ           = 310;
   localparam int SAMPLES_PER_CYCLE = 100;

   // LUT step rate: 100 samples per 310 Hz sine cycle = 31 kHz.
   localparam int SAMPLE_HZ = SINE_HZ * SAMPLES_PER_CYCLE;

   // Two PWM periods per LUT step; period length rounded to the nearest clk (1613).
   localparam int DEF_PERIODS_PER_SAMPLE = 2;
   localparam int DEF_PERIOD =
      (CLK_HZ + (SAMPLE_HZ * DEF_PERIODS_PER_SAMPLE) / 2) / (SAMPLE_HZ * DEF_PERIODS_PER_SAMPLE);

   localparam int DEF_DEAD_TIME = 8;
   localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/pwm_dead_time_gen_if.sv
// Signal bundle between the sine LUT stage (master) and the PWM generator (slave).
interface pwm_dead_time_gen_if;

   logic        enable;
   logic [31:0] duty_in;
   logic        sample_req;
   logic        period_start;
   logic        pwm_hi;
   logic        pwm_lo;

   // LUT / control side: drives run/stop and the duty word, watches the strobes and gates.
   modport master (
      output enable, duty_in,
      input  sample_req, period_start, pwm_hi, pwm_lo
   );

   // PWM generator side.
   modport slave (
      input  enable, duty_in,
      output sample_req, period_start, pwm_hi, pwm_lo
   );

endinterface

// File: rtl/dead_time_fsm.sv
// Break-before-make sequencer: turns the raw PWM level into complementary gate
// drives with at least max(DEAD_TIME,1) clk of both-off at every transition.
module dead_time_fsm
   import pwm_pkg::*;
#(
   parameter int DEAD_TIME = DEF_DEAD_TIME
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic raw,
   output logic pwm_hi,
   output logic pwm_lo
);

   // Wide enough to hold DEAD_TIME and the restart value 1, also for DEAD_TIME=0.
   localparam int DT_W = $clog2(DEAD_TIME + 2);

   dt_state_t        state, state_nxt;
   logic             target, target_nxt;
   logic [DT_W-1:0]  dt_cnt, dt_cnt_nxt;

   // State register, dead-time counter and the level we are heading towards.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state  <= IDLE;
         target <= 1'b0;
         dt_cnt <= '0;
      end else begin
         state  <= state_nxt;
         target <= target_nxt;
         dt_cnt <= dt_cnt_nxt;
      end
   end

   // Next-state logic; dt_cnt counts dead cycles already spent, starting at 1.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path infers a latch.
      state_nxt  = state;
      target_nxt = target;
      dt_cnt_nxt = dt_cnt;

      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               state_nxt  = DEAD;
               target_nxt = raw;
               dt_cnt_nxt = DT_W'(1);
            end
            DEAD: begin
               if (raw != target) begin
                  // Raw bounced back: aim at the new level and time the full gap again.
                  target_nxt = raw;
                  dt_cnt_nxt = DT_W'(1);
               end else if (int'(dt_cnt) >= DEAD_TIME) begin
                  state_nxt = target ? HI_ON : LO_ON;
               end else begin
                  dt_cnt_nxt = dt_cnt + 1'b1;
               end
            end
            HI_ON: begin
               if (!raw) begin
                  state_nxt  = DEAD;
                  target_nxt = 1'b0;
                  dt_cnt_nxt = DT_W'(1);
               end
            end
            LO_ON: begin
               if (raw) begin
                  state_nxt  = DEAD;
                  target_nxt = 1'b1;
                  dt_cnt_nxt = DT_W'(1);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Gates decode straight from the state register, so they can never overlap.
   assign pwm_hi = (state == HI_ON);
   assign pwm_lo = (state == LO_ON);

endmodule

// File: rtl/pwm_dead_time_gen.sv
// Complementary PWM generator fed by the sine duty LUT: period counter, duty
// shadow register, LUT step strobe and the dead-time sequencer.
module pwm_dead_time_gen
   import pwm_pkg::*;
#(
   parameter int PERIOD             = DEF_PERIOD,
   parameter int PERIODS_PER_SAMPLE = DEF_PERIODS_PER_SAMPLE,
   parameter int DEAD_TIME          = DEF_DEAD_TIME,
   parameter int CNT_W              = DEF_CNT_W      // 2**CNT_W must exceed PERIOD
) (
   input  logic               clk,
   input  logic               reset,
   pwm_dead_time_gen_if.slave bus
);

   localparam int PS_W = (PERIODS_PER_SAMPLE > 1) ? $clog2(PERIODS_PER_SAMPLE) : 1;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] FULL_ON  = CNT_W'(PERIOD);
   localparam logic [PS_W-1:0]  LAST_PS  = PS_W'(PERIODS_PER_SAMPLE - 1);

   logic [CNT_W-1:0] cnt;
   logic [PS_W-1:0]  per_cnt;
   logic [CNT_W-1:0] duty_eff;
   logic [CNT_W-1:0] duty_active;
   logic             raw;
   logic             wrap;

   assign wrap = (cnt == LAST_CNT);

   // Clamp on the full 32-bit word so large LUT values saturate instead of wrapping.
   always_comb begin
      duty_eff = bus.duty_in[CNT_W-1:0];
      if (bus.duty_in >= 32'(PERIOD)) duty_eff = FULL_ON;
   end

   // Period counter and periods-per-sample counter, parked at 0 while stopped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         per_cnt <= '0;
      end else if (!bus.enable) begin
         cnt     <= '0;
         per_cnt <= '0;
      end else if (wrap) begin
         cnt     <= '0;
         per_cnt <= (per_cnt == LAST_PS) ? '0 : per_cnt + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Duty shadow: follows the input while stopped, otherwise only updates on the last clk of a period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         duty_active <= '0;
      end else if (!bus.enable || wrap) begin
         duty_active <= duty_eff;
      end
   end

   // Registered raw PWM level and the period / sample strobes, all one clk behind cnt.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         raw              <= 1'b0;
         bus.period_start <= 1'b0;
         bus.sample_req   <= 1'b0;
      end else begin
         raw              <= (cnt < duty_active);
         bus.period_start <= bus.enable && (cnt == '0);
         bus.sample_req   <= bus.enable && (cnt == '0) && (per_cnt == '0);
      end
   end

   dead_time_fsm #(
      .DEAD_TIME (DEAD_TIME)
   ) u_dead_time_fsm (
      .clk    (clk),
      .reset  (reset),
      .enable (bus.enable),
      .raw    (raw),
      .pwm_hi (bus.pwm_hi),
      .pwm_lo (bus.pwm_lo)
   );

endmodule

// File: tb/tb_pwm_dead_time_gen.sv
// Bench for pwm_dead_time_gen: one instance with DEAD_TIME=0 (a) and one with
// DEAD_TIME=2 (b), both with PERIOD=10 and two periods per LUT step.
module tb_pwm_dead_time_gen;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   pwm_dead_time_gen_if if_a ();
   pwm_dead_time_gen_if if_b ();

   pwm_dead_time_gen #(
      .PERIOD(10), .PERIODS_PER_SAMPLE(2), .DEAD_TIME(0), .CNT_W(16)
   ) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (if_a.slave)
   );

   pwm_dead_time_gen #(
      .PERIOD(10), .PERIODS_PER_SAMPLE(2), .DEAD_TIME(2), .CNT_W(16)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (if_b.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit mon_on = 1'b0;

   // Expected values queued when a stimulus is applied, popped when its result is measured.
   int exp_q[$];

   // Steady-state counts over a 20-clk window (two PWM periods, one LUT step).
   typedef struct {
      bit          use_b;
      logic [31:0] duty;
      int          hi;
      int          lo;
      int          both;
      int          ps;
      int          sr;
   } vec_t;

   vec_t vecs [10];

   logic [3:0] o;
   int         run;
   int         guard;
   int         m_hi, m_lo, m_both, m_ps, m_sr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // {pwm_hi, pwm_lo, period_start, sample_req} of the chosen instance.
   function automatic logic [3:0] outs(input bit b);
      if (b) return {if_b.pwm_hi, if_b.pwm_lo, if_b.period_start, if_b.sample_req};
      return {if_a.pwm_hi, if_a.pwm_lo, if_a.period_start, if_a.sample_req};
   endfunction

   task automatic measure(input bit b, input int n,
                          output int hi, output int lo, output int both,
                          output int ps, output int sr);
      logic [3:0] v;
      hi = 0; lo = 0; both = 0; ps = 0; sr = 0;
      repeat (n) begin
         @(negedge clk);
         v = outs(b);
         if (v[3] === 1'b1) hi++;
         if (v[2] === 1'b1) lo++;
         if (v[3] === 1'b0 && v[2] === 1'b0) both++;
         if (v[1] === 1'b1) ps++;
         if (v[0] === 1'b1) sr++;
      end
   endtask

   // Bounded wait for the next period_start pulse; leaves the bench at that negedge.
   task automatic wait_ps(input bit b, input string name);
      logic [3:0] v;
      int g;
      v = 4'b0;
      g = 0;
      while (g < 30) begin
         @(negedge clk);
         g++;
         v = outs(b);
         if (v[1] === 1'b1) break;
      end
      check(name, v[1], 1);
   endtask

   // Gates must never be on together, checked every clk once reset has been applied.
   always @(negedge clk) begin
      if (mon_on) begin
         check("overlap_a", if_a.pwm_hi & if_a.pwm_lo, 0);
         check("overlap_b", if_b.pwm_hi & if_b.pwm_lo, 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 32'd4,          6, 10, 4, 2, 1};
      vecs[1] = '{1'b0, 32'd0,          0, 20, 0, 2, 1};
      vecs[2] = '{1'b0, 32'hFFFF_FFFF, 20,  0, 0, 2, 1};
      vecs[3] = '{1'b0, 32'd10,        20,  0, 0, 2, 1};
      vecs[4] = '{1'b0, 32'd7,         12,  4, 4, 2, 1};
      vecs[5] = '{1'b0, 32'd11,        20,  0, 0, 2, 1};
      vecs[6] = '{1'b1, 32'd4,          4,  8, 8, 2, 1};
      vecs[7] = '{1'b1, 32'd1,          0, 14, 6, 2, 1};
      vecs[8] = '{1'b1, 32'd6,          8,  4, 8, 2, 1};
      vecs[9] = '{1'b1, 32'h0001_0004, 20,  0, 0, 2, 1};

      // Reset with both instances stopped.
      reset = 1'b0;
      if_a.enable = 1'b0; if_a.duty_in = 32'd4;
      if_b.enable = 1'b0; if_b.duty_in = 32'd4;
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outs_a", outs(0), 0);
      check("reset_outs_b", outs(1), 0);
      mon_on = 1'b1;
      reset = 1'b0;

      // Stopped: gates and strobes stay low.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("disabled_outs_a", outs(0), 0);
         check("disabled_outs_b", outs(1), 0);
      end

      // Enable rises: first strobes one clk later, then every 10 / 20 clk.
      if_a.enable = 1'b1;
      if_b.enable = 1'b1;
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         for (int b = 0; b < 2; b++) begin
            o = outs(b[0]);
            check($sformatf("start_sr_%0d_k%0d", b, k), o[0], (k % 20) == 1);
            check($sformatf("start_ps_%0d_k%0d", b, k), o[1], (k % 10) == 1);
         end
      end

      // Steady-state patterns from the vector table.
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].use_b) if_b.duty_in = vecs[i].duty;
         else               if_a.duty_in = vecs[i].duty;
         exp_q.push_back(vecs[i].hi);
         exp_q.push_back(vecs[i].lo);
         exp_q.push_back(vecs[i].both);
         exp_q.push_back(vecs[i].ps);
         exp_q.push_back(vecs[i].sr);
         repeat (30) @(negedge clk);
         measure(vecs[i].use_b, 20, m_hi, m_lo, m_both, m_ps, m_sr);
         check($sformatf("vec%0d_hi", i),   m_hi,   exp_q.pop_front());
         check($sformatf("vec%0d_lo", i),   m_lo,   exp_q.pop_front());
         check($sformatf("vec%0d_both", i), m_both, exp_q.pop_front());
         check($sformatf("vec%0d_ps", i),   m_ps,   exp_q.pop_front());
         check($sformatf("vec%0d_sr", i),   m_sr,   exp_q.pop_front());
      end

      // Mid-period duty change 4 -> 7 at cnt==3: current high run stays 3, next is 6.
      if_a.duty_in = 32'd4;
      repeat (30) @(negedge clk);
      wait_ps(0, "shadow_sync");
      repeat (2) @(negedge clk);
      exp_q.push_back(3);
      exp_q.push_back(6);
      if_a.duty_in = 32'd7;
      o = outs(0);
      run = 0;
      while (o[3] === 1'b1 && run < 20) begin
         run++;
         @(negedge clk);
         o = outs(0);
      end
      check("shadow_cur_hi_run", run, exp_q.pop_front());
      guard = 0;
      while (o[3] !== 1'b1 && guard < 20) begin
         guard++;
         @(negedge clk);
         o = outs(0);
      end
      run = 0;
      while (o[3] === 1'b1 && run < 20) begin
         run++;
         @(negedge clk);
         o = outs(0);
      end
      check("shadow_next_hi_run", run, exp_q.pop_front());

      // Enable falls on b while its high gate is on: everything low from the next clk.
      guard = 0;
      o = outs(1);
      while (o[3] !== 1'b1 && guard < 20) begin
         guard++;
         @(negedge clk);
         o = outs(1);
      end
      check("stop_hi_before", o[3], 1);
      if_b.enable = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check($sformatf("stop_outs_k%0d", k), outs(1), 0);
      end

      // Reset at cnt==5 with pwm_hi on: outputs clear without a clock edge, restart from cnt 0.
      if_a.duty_in = 32'd4;
      repeat (30) @(negedge clk);
      wait_ps(0, "rst_sync");
      repeat (4) @(negedge clk);
      o = outs(0);
      check("rst_hi_before", o[3], 1);
      #1 reset = 1'b1;
      #1 check("rst_async_outs_a", outs(0), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 21; k++) begin
         @(negedge clk);
         o = outs(0);
         check($sformatf("restart_sr_k%0d", k), o[0], (k == 1) || (k == 21));
         check($sformatf("restart_ps_k%0d", k), o[1], (k % 10) == 1);
      end

      check("scoreboard_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
